// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int PS2_EVT_W = $bits(ps2_evt_t);

endpackage

// File: rtl/ps2_event_fifo.sv
// Event FIFO with a registered head entry; level counts the head register too.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             pop;
    logic             push_ok;
    logic             load;
    logic             mem_empty;
    logic             rd_en;
    logic             wr_en;

    assign empty     = (count == '0);
    assign full      = (count == LW'(DEPTH));
    assign level     = count;
    assign pop       = ready & ~empty;
    assign push_ok   = push & (~full | pop);
    assign load      = pop | empty;
    // Head register holds one entry, so storage is empty at count <= 1.
    assign mem_empty = (count <= LW'(1));
    assign rd_en     = load & ~mem_empty;
    assign wr_en     = push_ok & ~(load & mem_empty);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                head   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end else if (load && push_ok) begin
                head <= din;
            end
            count <= count + LW'(push_ok) - LW'(pop);
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: sync, frame FSM, timeout, E0/F0 decode, event FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_ext,
    output logic                        evt_break,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_err,
    output logic                        overflow
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fe;
    ps2_state_t             state_q;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_good;
    logic                   byte_done;
    logic [TW-1:0]          tcnt;
    logic                   tmo;
    logic                   ext_pend;
    logic                   brk_pend;
    logic                   is_ext;
    logic                   is_brk;
    logic                   push;
    ps2_evt_t               push_evt;
    ps2_evt_t               head;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign fe    = clk_prev & ~clk_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_s;
        end
    end

    assign tmo = (state_q != ST_IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (fe || state_q == ST_IDLE) begin
            tcnt <= '0;
        end else if (!tmo) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_good  <= 1'b0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            if (tmo) begin
                state_q   <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (fe) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!dat_s) begin
                            state_q <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_good <= ~PAR_CHECK | (^{shreg, dat_s});
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (dat_s && par_good) begin
                            byte_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // shreg stays untouched in IDLE, so it still holds the byte at byte_done.
    assign is_ext   = (shreg == PS2_PREFIX_EXT);
    assign is_brk   = (shreg == PS2_PREFIX_BRK);
    assign push     = byte_done & ~is_ext & ~is_brk;
    assign push_evt = {ext_pend, brk_pend, shreg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (frame_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_done) begin
            if (is_ext) begin
                ext_pend <= 1'b1;
            end else if (is_brk) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_EVT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_evt),
        .ready (evt_ready),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;
    assign overflow  = push & fifo_full & ~(evt_valid & evt_ready);

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver that replaces the single-byte keyboard driver. It deserialises 11-bit device-to-host frames and checks start, parity and stop bits. It recovers from stalled frames by timeout, decodes the E0/F0 prefixes into per-key events, and buffers events in a FIFO behind a valid/ready interface. It sits between the board PS/2 pins and the game control logic.

## Interface
- SYNC_STAGES, 3: synchroniser depth on ps2_clk and ps2_data; minimum 2.
- TIMEOUT_CYCLES, 100000: clk cycles without a ps2_clk falling edge before an in-progress frame is abandoned.
- FIFO_DEPTH, 8: event FIFO entries; power of two, minimum 2.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- ps2_clk  input  1  raw PS/2 clock pin.
- ps2_data  input  1  raw PS/2 data pin.
- evt_valid  output  1  head-of-FIFO event available.
- evt_ready  input  1  consumer accepts the head event.
- evt_code  output  8  scan code of the head event.
- evt_ext  output  1  head event was preceded by E0.
- evt_break  output  1  head event is a release (preceded by F0).
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err  output  1  one-cycle pulse per rejected frame.
- overflow  output  1  one-cycle pulse per event dropped because the FIFO was full.

## Operation
- Synchronise both pins through SYNC_STAGES flops, each reset to 1.
- Falling-edge pulse fe = previous synchronised clk high AND current synchronised clk low.
- Frame FSM states: IDLE, DATA, PARITY, STOP. All transitions occur on fe.
  - IDLE: data 0 → DATA with bit count cleared. Data 1 → stay in IDLE; this is a glitch, not an error.
  - DATA: shift in 8 bits LSB first; after bit 7 → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: data 1 and parity good → byte complete. Otherwise frame_err. Both cases → IDLE.
- Timeout: a counter clears on every fe and in IDLE. When it reaches TIMEOUT_CYCLES outside IDLE → IDLE, pulse frame_err, discard partial bits.
- Prefix decoder, acting on each complete byte:
  - E0 sets ext_pend.
  - F0 sets brk_pend.
  - Any other byte, including E1, pushes {ext_pend, brk_pend, byte}, then clears both flags.
- Any frame_err clears ext_pend and brk_pend.
- FIFO:
  - A push while full with no pop in the same cycle is dropped and pulses overflow.
  - A push and pop in the same cycle when full are both accepted; level unchanged.
  - A pop occurs on evt_valid AND evt_ready. evt_ready while empty has no effect.
  - evt_code, evt_ext and evt_break hold stable while evt_valid is high and not popped.
- Reset values: evt_valid 0, evt_code 00, evt_ext 0, evt_break 0, fifo_level 0, frame_err 0, overflow 0. FSM to IDLE, prefix flags 0, FIFO pointers 0.
- Reset mid-frame discards the partial frame and all FIFO contents.

## Timing
- Cycle E is the fe cycle of a valid stop bit.
- Push occurs at E+1. With the FIFO empty, evt_valid and the fields are registered high at E+2.
- fifo_level updates the cycle after each push or pop.
- frame_err and overflow are asserted for exactly one cycle.
  - frame_err: at E+1 for a stop or parity failure, or on the cycle the timeout expires.
  - overflow: on the cycle of the rejected push.
- Prefix bytes produce no event and no level change.
- Pin-to-fe latency is SYNC_STAGES+1 clk cycles.

## Configuration
- PS2_PARITY_CHECK_EN defined: the parity bit must give odd parity over data+parity. A mismatch yields frame_err and discards the byte; prefix flags clear.
- PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored; only start and stop bits are checked.

## Structure
- Package ps2_pkg holds:
  - frame FSM state enum.
  - constants PS2_PREFIX_EXT = 8'hE0 and PS2_PREFIX_BRK = 8'hF0.
  - event struct {ext, brk, code[7:0]}.
- One sub-module, ps2_event_fifo: synchronous FIFO parametrised by FIFO_DEPTH and entry width 10, with a registered head output, full/empty flags and level.
- Top level contains the synchronisers, frame FSM, timeout counter and prefix decoder.

## Test plan
- Frame 1C (parity 0, stop 1), evt_ready held 1 → one event: code 1C, ext 0, break 0; evt_valid 2 cycles after the stop fe.
- Frames F0,1C then E0,F0,75 → events {1C, ext 0, break 1} and {75, ext 1, break 1}; no events for the prefix bytes.
- Frame 1C with parity 1, macro defined → frame_err pulse, no event, level 0. Macro undefined → event 1C.
- Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES → frame_err pulse, FSM in IDLE; next full frame 29 decodes correctly.
- evt_ready 0, FIFO_DEPTH+1 frames of 1C → level = FIFO_DEPTH, one overflow pulse. Then evt_ready 1 → FIFO_DEPTH events drained in order.
- rst asserted after 3 data bits with 2 events queued → all outputs at reset values; next frame 5A yields exactly one event 5A.
